// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped parameter cache.
// FSM states, access size encodings and the uncached address window.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_RM,
    S_WM,
    S_UC
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] UC_REGION = 3'b101;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/byte_merge.sv
// Store lane merge: overlays the sized, lane-aligned store data
// onto an existing word.
module byte_merge
  import cache_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  output logic [31:0] merged
);

  logic [4:0] bit_lo;

  assign bit_lo = {offset, 3'b000};

  always_comb begin
    merged = old;
    unique case (size)
      SZ_BYTE: merged[bit_lo +: 8] = wdata[bit_lo +: 8];
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[31:16];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/param_cache.sv
// Direct-mapped one-word-per-line cache with an SRAM-like CPU side
// and memory side; write-back or write-through by parameter.
module param_cache
  import cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 10,
  parameter bit WRITE_BACK  = 1'b1,
  parameter bit UNCACHED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic        cache_req,
  output logic        cache_wr,
  output logic [1:0]  cache_size,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  input  logic [31:0] cache_rdata,
  input  logic        cache_addr_ok,
  input  logic        cache_data_ok
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef logic [TAG_W-1:0]       tag_t;

  logic [31:0] data_mem [LINES];
  tag_t        tag_mem  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  state_t state, nxt;
  req_t   rq;
  logic   pend;
  logic   hit_ok;
  logic [31:0] rdata_q;

  idx_t in_idx, r_idx;
  tag_t in_tag, r_tag;
  logic in_uc, in_hit, accept, mem_done;
  logic wt_store, victim_dirty, rd_done;

  logic [1:0]  m_size, m_off;
  logic [31:0] m_old, m_wdata, merged;

  assign in_idx = cpu_addr[INDEX_WIDTH+1:2];
  assign in_tag = cpu_addr[31:INDEX_WIDTH+2];
  assign r_idx  = rq.addr[INDEX_WIDTH+1:2];
  assign r_tag  = rq.addr[31:INDEX_WIDTH+2];

  assign in_uc  = UNCACHED_EN && (cpu_addr[31:29] == UC_REGION);
  assign in_hit = !in_uc && valid_q[in_idx]
                  && (tag_mem[in_idx] == in_tag);

  assign wt_store     = cpu_wr && !WRITE_BACK;
  assign victim_dirty = valid_q[in_idx] && dirty_q[in_idx];

  assign accept      = cpu_addr_ok;
  assign cpu_addr_ok = rst && cpu_req && (state == S_IDLE);

  // Data beats only count once our address has been taken.
  assign mem_done = pend && cache_data_ok && (state != S_IDLE);
  assign rd_done  = mem_done && !rq.wr
                    && (state == S_RM || state == S_UC);

  assign m_size  = (state == S_IDLE) ? cpu_size       : rq.size;
  assign m_off   = (state == S_IDLE) ? cpu_addr[1:0]  : rq.addr[1:0];
  assign m_old   = (state == S_IDLE) ? data_mem[in_idx] : cache_rdata;
  assign m_wdata = (state == S_IDLE) ? cpu_wdata      : rq.wdata;

  byte_merge u_merge (
    .size   (m_size),
    .offset (m_off),
    .old    (m_old),
    .wdata  (m_wdata),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_uc)             nxt = cpu_wr ? S_WM : S_UC;
          else if (in_hit)       nxt = wt_store ? S_WM : S_IDLE;
          else if (wt_store)     nxt = S_WM;
          else if (victim_dirty) nxt = S_WB;
          else                   nxt = S_RM;
        end
      end
      S_WB:    if (mem_done) nxt = S_RM;
      S_RM,
      S_WM,
      S_UC:    if (mem_done) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cache_req   = 1'b0;
    cache_wr    = 1'b0;
    cache_size  = 2'd0;
    cache_addr  = 32'd0;
    cache_wdata = 32'd0;
    unique case (state)
      S_WB: begin
        cache_req   = !pend;
        cache_wr    = 1'b1;
        cache_size  = SZ_WORD;
        cache_addr  = {tag_mem[r_idx], r_idx, 2'b00};
        cache_wdata = data_mem[r_idx];
      end
      S_RM: begin
        cache_req  = !pend;
        cache_size = SZ_WORD;
        cache_addr = {rq.addr[31:2], 2'b00};
      end
      S_WM: begin
        cache_req   = !pend;
        cache_wr    = 1'b1;
        cache_size  = rq.size;
        cache_addr  = rq.addr;
        cache_wdata = rq.wdata;
      end
      S_UC: begin
        cache_req  = !pend;
        cache_size = rq.size;
        cache_addr = rq.addr;
      end
      default: ;
    endcase
  end

  assign cpu_data_ok = hit_ok || (mem_done && state != S_WB);
  assign cpu_rdata   = rd_done ? cache_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= 1'b0;
      hit_ok  <= 1'b0;
      rdata_q <= 32'd0;
      rq      <= '0;
    end else begin
      if (cache_req && cache_addr_ok) pend <= 1'b1;
      else if (mem_done)              pend <= 1'b0;
      hit_ok <= accept && in_hit && !wt_store;
      if (accept) rq <= '{cpu_wr, cpu_size, cpu_addr, cpu_wdata};
      if (accept && in_hit && !cpu_wr) rdata_q <= data_mem[in_idx];
      else if (rd_done)                rdata_q <= cache_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (accept && in_hit && cpu_wr) begin
      dirty_q[in_idx] <= WRITE_BACK;
    end else if (mem_done && state == S_RM) begin
      valid_q[r_idx] <= 1'b1;
      dirty_q[r_idx] <= rq.wr;
    end
  end

  // Line payload needs no reset: valid_q guards every use.
  always_ff @(posedge clk) begin
    if (accept && in_hit && cpu_wr) begin
      data_mem[in_idx] <= merged;
    end else if (mem_done && state == S_RM) begin
      data_mem[r_idx] <= rq.wr ? merged : cache_rdata;
      tag_mem[r_idx]  <= r_tag;
    end
  end

endmodule

// File: tb/tb_param_cache.sv
// Directed bench for param_cache: write-back and write-through
// instances behind one CPU driver and one memory responder.
module tb_param_cache;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;

  logic [31:0] rdata_a, rdata_b, waddr_a, waddr_b, wdat_a, wdat_b;
  logic        aok_a, aok_b, dok_a, dok_b, req_a, req_b, wr_a, wr_b;
  logic [1:0]  size_a, size_b;

  logic [31:0] cache_rdata = 32'd0;
  logic        cache_addr_ok = 1'b0;
  logic        cache_data_ok = 1'b0;

  logic [31:0] o_rdata, m_addr, m_wdata;
  logic        o_aok, o_dok, m_req, m_wr;
  logic [1:0]  m_size;

  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_aok   = sel ? aok_b : aok_a;
  assign o_dok   = sel ? dok_b : dok_a;
  assign m_req   = sel ? req_b : req_a;
  assign m_wr    = sel ? wr_b : wr_a;
  assign m_size  = sel ? size_b : size_a;
  assign m_addr  = sel ? waddr_b : waddr_a;
  assign m_wdata = sel ? wdat_b : wdat_a;

  param_cache #(.INDEX_WIDTH(10), .WRITE_BACK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req && !sel), .cpu_wr(cpu_wr),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_a),
    .cpu_addr_ok(aok_a), .cpu_data_ok(dok_a),
    .cache_req(req_a), .cache_wr(wr_a), .cache_size(size_a),
    .cache_addr(waddr_a), .cache_wdata(wdat_a),
    .cache_rdata(cache_rdata),
    .cache_addr_ok(cache_addr_ok && !sel),
    .cache_data_ok(cache_data_ok && !sel)
  );

  param_cache #(.INDEX_WIDTH(10), .WRITE_BACK(1'b0)) dut_wt (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req && sel), .cpu_wr(cpu_wr),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_b),
    .cpu_addr_ok(aok_b), .cpu_data_ok(dok_b),
    .cache_req(req_b), .cache_wr(wr_b), .cache_size(size_b),
    .cache_addr(waddr_b), .cache_wdata(wdat_b),
    .cache_rdata(cache_rdata),
    .cache_addr_ok(cache_addr_ok && sel),
    .cache_data_ok(cache_data_ok && sel)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_rd = 32'd0;
  logic        hold = 1'b0;
  logic        owe = 1'b0;
  req_t        lg[$];

  always @(negedge clk) begin
    cache_addr_ok = 1'b0;
    cache_data_ok = 1'b0;
    if (owe) begin
      cache_data_ok = 1'b1;
      cache_rdata   = mem_rd;
      owe = 1'b0;
    end else if (!hold && m_req) begin
      cache_addr_ok = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst && m_req && cache_addr_ok) begin
      lg.push_back('{m_wr, m_size, m_addr, m_wdata});
      owe = 1'b1;
    end
  end

  logic [31:0] rd;
  int          lat;
  logic        same;

  task automatic cpu_op(input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = sz;
    cpu_addr = a; cpu_wdata = wd;
    #1;
    checks++;
    if (o_aok !== 1'b1) begin
      errors++;
      $display("FAIL addr_ok %h got %b want 1", a, o_aok);
    end
    @(posedge clk);
    #1 cpu_req = 1'b0;
    lat = 0; same = 1'b0; rd = 32'hx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      lat++;
      if (o_dok) begin
        rd = o_rdata; same = cache_data_ok;
        break;
      end
    end
    checks++;
    if (o_dok !== 1'b1) begin
      errors++;
      $display("FAIL timeout %h got no data_ok want data_ok", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({o_aok, o_dok, m_req, o_rdata, m_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outs got %b%b%b %h %h want all 0",
               o_aok, o_dok, m_req, o_rdata, m_addr);
    end
    cpu_req = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_load_miss();
    int n;
    mem_rd = 32'hDEADBEEF; n = lg.size();
    cpu_op(1'b0, SZ_WORD, 32'h0000_1004, 32'd0);
    checks++;
    if (lg.size() !== n + 1 ||
        lg[n] !== '{1'b0, SZ_WORD, 32'h0000_1004, 32'd0}) begin
      errors++;
      $display("FAIL miss_req got %0d reqs want 1 rd 00001004 sz2",
               lg.size() - n);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || same !== 1'b1) begin
      errors++;
      $display("FAIL miss_data got %h same=%b want deadbeef same=1",
               rd, same);
    end
    n = lg.size();
    cpu_op(1'b0, SZ_WORD, 32'h0000_1004, 32'd0);
    checks++;
    if (lg.size() !== n || lat !== 1 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reload got reqs=%0d lat=%0d %h want 0 1 deadbeef",
               lg.size() - n, lat, rd);
    end
  endtask

  task automatic test_store_hit();
    int n;
    n = lg.size();
    cpu_op(1'b1, SZ_BYTE, 32'h0000_1005, 32'h0000_5500);
    checks++;
    if (lg.size() !== n || lat !== 1) begin
      errors++;
      $display("FAIL sb_hit got reqs=%0d lat=%0d want 0 1",
               lg.size() - n, lat);
    end
    cpu_op(1'b0, SZ_WORD, 32'h0000_1004, 32'd0);
    checks++;
    if (lg.size() !== n || rd !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL merge got reqs=%0d %h want 0 dead55ef",
               lg.size() - n, rd);
    end
  endtask

  task automatic test_evict();
    int n;
    mem_rd = 32'hCAFEF00D; n = lg.size();
    cpu_op(1'b0, SZ_WORD, 32'h0000_2004, 32'd0);
    checks++;
    if (lg.size() !== n + 2 ||
        lg[n] !== '{1'b1, SZ_WORD, 32'h0000_1004, 32'hDEAD55EF}) begin
      errors++;
      $display("FAIL victim_wr got %0d reqs want wr 00001004 dead55ef",
               lg.size() - n);
    end
    checks++;
    if (lg.size() !== n + 2 ||
        lg[n+1] !== '{1'b0, SZ_WORD, 32'h0000_2004, 32'd0}) begin
      errors++;
      $display("FAIL refill_rd got %0d reqs want rd 00002004",
               lg.size() - n);
    end
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL evict_data got %h want cafef00d", rd);
    end
  endtask

  task automatic test_uncached();
    int n;
    mem_rd = 32'h1234_56AB;
    for (int k = 0; k < 2; k++) begin
      n = lg.size();
      cpu_op(1'b0, SZ_BYTE, 32'hA000_0013, 32'd0);
      checks++;
      if (lg.size() !== n + 1 ||
          lg[n] !== '{1'b0, SZ_BYTE, 32'hA000_0013, 32'd0}) begin
        errors++;
        $display("FAIL uc_req%0d got %0d reqs want rd a0000013 sz0",
                 k, lg.size() - n);
      end
      checks++;
      if (rd !== 32'h1234_56AB || same !== 1'b1) begin
        errors++;
        $display("FAIL uc_data%0d got %h same=%b want 123456ab 1",
                 k, rd, same);
      end
    end
    n = lg.size();
    cpu_op(1'b0, SZ_WORD, 32'h0000_2004, 32'd0);
    checks++;
    if (lg.size() !== n || lat !== 1 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL uc_array got reqs=%0d lat=%0d %h want 0 1 cafef00d",
               lg.size() - n, lat, rd);
    end
  endtask

  task automatic test_write_through();
    int n;
    sel = 1'b1; n = lg.size();
    cpu_op(1'b1, SZ_WORD, 32'h0000_3000, 32'h1234_5678);
    checks++;
    if (lg.size() !== n + 1 ||
        lg[n] !== '{1'b1, SZ_WORD, 32'h0000_3000, 32'h1234_5678}) begin
      errors++;
      $display("FAIL wt_write got %0d reqs want wr 00003000 12345678",
               lg.size() - n);
    end
    mem_rd = 32'h1234_5678; n = lg.size();
    cpu_op(1'b0, SZ_WORD, 32'h0000_3000, 32'd0);
    checks++;
    if (lg.size() !== n + 1 || lg[n].wr !== 1'b0) begin
      errors++;
      $display("FAIL wt_noalloc got %0d reqs want 1 read",
               lg.size() - n);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    hold = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = SZ_WORD;
    cpu_addr = 32'h0000_1004;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    checks++;
    if (m_req !== 1'b1) begin
      errors++;
      $display("FAIL rm_req got %b want 1", m_req);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (m_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop got %b want 0", m_req);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; hold = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      seen |= o_dok;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abandon got data_ok=%b want 0", seen);
    end
    mem_rd = 32'h0BAD_F00D; n = lg.size();
    cpu_op(1'b0, SZ_WORD, 32'h0000_1004, 32'd0);
    checks++;
    if (lg.size() !== n + 1 || rd !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL post_rst got reqs=%0d %h want 1 0badf00d",
               lg.size() - n, rd);
    end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_evict();
    test_uncached();
    test_write_through();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
